// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: RV32 opcodes,
// FSM state encoding, datapath mux encodings and trap causes.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDU  = 7'b0000001;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_MDU_WAIT = 3'd5,
    S_TRAP     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_ALU   = 2'b01,
    PC_TRAP  = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_IMM_U = 2'b00,
    WB_ALU   = 2'b01,
    WB_MEM   = 2'b10,
    WB_PC4   = 2'b11
  } wb_src_t;

  typedef enum logic {
    A1_RS1 = 1'b0,
    A1_PC  = 1'b1
  } alu_src_1_t;

  typedef enum logic [1:0] {
    A2_IMM_I   = 2'b00,
    A2_IMM_S   = 2'b01,
    A2_RS2     = 2'b10,
    A2_IMM_UBJ = 2'b11
  } alu_src_2_t;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'b00,
    CAUSE_BUS     = 2'b01
  } trap_cause_t;

  typedef struct packed {
    logic       legal;
    logic       branch;
    logic       jump;
    logic       load;
    logic       store;
    logic       mdu;
    wb_src_t    wb_src;
    alu_src_1_t alu_1;
    alu_src_2_t alu_2;
  } dec_t;

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction decode: opcode/funct3/funct7 -> legality,
// instruction class and datapath selects.
// Ports: opcode_i/funct3_i/funct7_i in; dec_o decoded bundle out.
// Macro MULTICYCLE_CONTROL_MDU_EN makes OP with funct7=0000001 legal.
module insn_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output dec_t       dec_o
);

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_op_imm, is_op;
  logic op_base, op_mdu;

  assign is_lui    = opcode_i == OPC_LUI;
  assign is_auipc  = opcode_i == OPC_AUIPC;
  assign is_jal    = opcode_i == OPC_JAL;
  assign is_jalr   = opcode_i == OPC_JALR;
  assign is_branch = opcode_i == OPC_BRANCH;
  assign is_load   = opcode_i == OPC_LOAD;
  assign is_store  = opcode_i == OPC_STORE;
  assign is_op_imm = opcode_i == OPC_OP_IMM;
  assign is_op     = opcode_i == OPC_OP;

  // funct7=0100000 only exists for SUB and SRA
  assign op_base = (funct7_i == F7_BASE) ||
                   ((funct7_i == F7_ALT) &&
                    (funct3_i == 3'b000 || funct3_i == 3'b101));

`ifdef MULTICYCLE_CONTROL_MDU_EN
  assign op_mdu = funct7_i == F7_MDU;
`else
  assign op_mdu = 1'b0;
`endif

  always_comb begin
    dec_o        = '0;
    dec_o.wb_src = WB_IMM_U;
    dec_o.alu_1  = A1_RS1;
    dec_o.alu_2  = A2_IMM_I;
    unique case (1'b1)
      is_lui: begin
        dec_o.legal  = 1'b1;
        dec_o.wb_src = WB_IMM_U;
        dec_o.alu_2  = A2_IMM_UBJ;
      end
      is_auipc: begin
        dec_o.legal  = 1'b1;
        dec_o.wb_src = WB_ALU;
        dec_o.alu_1  = A1_PC;
        dec_o.alu_2  = A2_IMM_UBJ;
      end
      is_jal: begin
        dec_o.legal  = 1'b1;
        dec_o.jump   = 1'b1;
        dec_o.wb_src = WB_PC4;
        dec_o.alu_1  = A1_PC;
        dec_o.alu_2  = A2_IMM_UBJ;
      end
      is_jalr: begin
        dec_o.legal  = funct3_i == 3'b000;
        dec_o.jump   = 1'b1;
        dec_o.wb_src = WB_PC4;
      end
      is_branch: begin
        dec_o.legal  = 1'b1;
        dec_o.branch = 1'b1;
        dec_o.alu_1  = A1_PC;
        dec_o.alu_2  = A2_IMM_UBJ;
      end
      is_load: begin
        dec_o.legal  = 1'b1;
        dec_o.load   = 1'b1;
        dec_o.wb_src = WB_MEM;
      end
      is_store: begin
        dec_o.legal  = 1'b1;
        dec_o.store  = 1'b1;
        dec_o.alu_2  = A2_IMM_S;
      end
      is_op_imm: begin
        dec_o.legal  = 1'b1;
        dec_o.wb_src = WB_ALU;
      end
      is_op: begin
        dec_o.legal  = op_base || op_mdu;
        dec_o.mdu    = op_mdu;
        dec_o.wb_src = WB_ALU;
        dec_o.alu_2  = A2_RS2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM with memory wait counter and traps.
// Ports: clk_i, rst_i; instruction fields, branch/mem/mdu status in;
// memory, PC, regfile, ALU and MDU controls, trap, state_o out.
// Macro MULTICYCLE_CONTROL_MDU_EN enables the MUL/DIV wait state.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  input  logic       mdu_done_i,
  output logic       mem_req_o,
  output logic       mem_write_enable_o,
  output logic       mem_addr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_enable_o,
  output logic [1:0] reg_write_src_o,
  output logic       alu_src_1_o,
  output logic [1:0] alu_src_2_o,
  output logic       mdu_start_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic [2:0] state_o
);

  state_t            state_q, state_d;
  trap_cause_t       cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q;
  logic              limit;
  dec_t              dec;

  insn_decode u_dec (
    .opcode_i (opcode_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .dec_o    (dec)
  );

  // last allowed wait cycle: a further non-ready cycle traps
  assign limit   = cnt_q == CNT_W'(MEM_TIMEOUT - 1);
  assign state_o = state_q;

`ifndef MULTICYCLE_CONTROL_MDU_EN
  logic unused_mdu;
  assign unused_mdu = mdu_done_i;
`endif

  // run_q holds outputs quiet for the first cycle after reset release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_ILLEGAL;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (mem_ready_i) begin
            state_d = S_DECODE;
          end else if (limit) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
          end
        end
        S_DECODE: begin
          if (dec.legal) begin
            state_d = S_EXECUTE;
          end else begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end
        S_EXECUTE: begin
          if (dec.load || dec.store)
            state_d = S_MEM;
          else if (dec.branch || dec.jump)
            state_d = S_FETCH;
          else if (dec.mdu)
            state_d = S_MDU_WAIT;
          else
            state_d = S_WB;
        end
        S_MEM: begin
          if (mem_ready_i) begin
            state_d = dec.store ? S_FETCH : S_WB;
          end else if (limit) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
          end
        end
        S_MDU_WAIT: begin
`ifdef MULTICYCLE_CONTROL_MDU_EN
          if (mdu_done_i) state_d = S_WB;
`else
          state_d = S_FETCH;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // count only while parked in FETCH/MEM; any transition clears it
  always_comb begin
    cnt_d = '0;
    if (run_q && (state_q == S_FETCH || state_q == S_MEM) &&
        state_d == state_q)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    mem_req_o          = 1'b0;
    mem_write_enable_o = 1'b0;
    mem_addr_src_o     = 1'b0;
    ir_write_o         = 1'b0;
    pc_write_o         = 1'b0;
    pc_src_o           = PC_PLUS4;
    reg_write_enable_o = 1'b0;
    reg_write_src_o    = WB_IMM_U;
    alu_src_1_o        = A1_RS1;
    alu_src_2_o        = A2_IMM_I;
    mdu_start_o        = 1'b0;
    trap_o             = 1'b0;
    trap_cause_o       = CAUSE_ILLEGAL;
    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req_o  = 1'b1;
          ir_write_o = mem_ready_i;
        end
        S_EXECUTE: begin
          alu_src_1_o = dec.alu_1;
          alu_src_2_o = dec.alu_2;
          if (dec.branch) begin
            pc_write_o = 1'b1;
            pc_src_o   = branch_taken_i ? PC_ALU : PC_PLUS4;
          end
          if (dec.jump) begin
            pc_write_o         = 1'b1;
            pc_src_o           = PC_ALU;
            reg_write_enable_o = 1'b1;
            reg_write_src_o    = WB_PC4;
          end
`ifdef MULTICYCLE_CONTROL_MDU_EN
          mdu_start_o = dec.mdu;
`endif
        end
        S_MEM: begin
          mem_req_o          = 1'b1;
          mem_addr_src_o     = 1'b1;
          mem_write_enable_o = dec.store;
          pc_write_o         = dec.store && mem_ready_i;
        end
        S_WB: begin
          reg_write_enable_o = 1'b1;
          reg_write_src_o    = dec.mdu ? WB_ALU : dec.wb_src;
          pc_write_o         = 1'b1;
        end
        S_TRAP: begin
          trap_o       = 1'b1;
          pc_write_o   = 1'b1;
          pc_src_o     = PC_TRAP;
          trap_cause_o = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: every cycle the
// full output vector is predicted, queued, then popped and compared.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] opcode_i = 7'h0;
  logic [2:0] funct3_i = 3'h0;
  logic [6:0] funct7_i = 7'h0;
  logic       branch_taken_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mdu_done_i = 1'b0;
  logic       mem_req_o, mem_write_enable_o, mem_addr_src_o;
  logic       ir_write_o, pc_write_o;
  logic [1:0] pc_src_o;
  logic       reg_write_enable_o;
  logic [1:0] reg_write_src_o;
  logic       alu_src_1_o;
  logic [1:0] alu_src_2_o;
  logic       mdu_start_o, trap_o;
  logic [1:0] trap_cause_o;
  logic [2:0] state_o;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_src;
    logic       alu1;
    logic [1:0] alu2;
    logic       mdu_start;
    logic       trap;
    logic [1:0] cause;
    logic [2:0] state;
  } obs_t;

  obs_t  obs;
  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .opcode_i           (opcode_i),
    .funct3_i           (funct3_i),
    .funct7_i           (funct7_i),
    .branch_taken_i     (branch_taken_i),
    .mem_ready_i        (mem_ready_i),
    .mdu_done_i         (mdu_done_i),
    .mem_req_o          (mem_req_o),
    .mem_write_enable_o (mem_write_enable_o),
    .mem_addr_src_o     (mem_addr_src_o),
    .ir_write_o         (ir_write_o),
    .pc_write_o         (pc_write_o),
    .pc_src_o           (pc_src_o),
    .reg_write_enable_o (reg_write_enable_o),
    .reg_write_src_o    (reg_write_src_o),
    .alu_src_1_o        (alu_src_1_o),
    .alu_src_2_o        (alu_src_2_o),
    .mdu_start_o        (mdu_start_o),
    .trap_o             (trap_o),
    .trap_cause_o       (trap_cause_o),
    .state_o            (state_o)
  );

  assign obs = {mem_req_o, mem_write_enable_o, mem_addr_src_o,
                ir_write_o, pc_write_o, pc_src_o,
                reg_write_enable_o, reg_write_src_o,
                alu_src_1_o, alu_src_2_o, mdu_start_o,
                trap_o, trap_cause_o, state_o};

  function automatic obs_t f_st(input logic [2:0] s);
    obs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic obs_t f_fetch(input logic ir);
    obs_t o;
    o = f_st(3'd0);
    o.mem_req = 1'b1;
    o.ir_write = ir;
    return o;
  endfunction

  function automatic obs_t f_exe(input logic a1, input logic [1:0] a2);
    obs_t o;
    o = f_st(3'd2);
    o.alu1 = a1;
    o.alu2 = a2;
    return o;
  endfunction

  function automatic obs_t f_mem(input logic we, input logic pcw);
    obs_t o;
    o = f_st(3'd3);
    o.mem_req = 1'b1;
    o.addr_src = 1'b1;
    o.mem_we = we;
    o.pc_write = pcw;
    return o;
  endfunction

  function automatic obs_t f_wb(input logic [1:0] src);
    obs_t o;
    o = f_st(3'd4);
    o.reg_we = 1'b1;
    o.reg_src = src;
    o.pc_write = 1'b1;
    return o;
  endfunction

  function automatic obs_t f_trap(input logic [1:0] c);
    obs_t o;
    o = f_st(3'd6);
    o.trap = 1'b1;
    o.pc_write = 1'b1;
    o.pc_src = 2'b10;
    o.cause = c;
    return o;
  endfunction

  task automatic check();
    obs_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic rdy,
                      input logic tk, input logic dn, input obs_t e);
    @(negedge clk);
    rst_i = r;
    mem_ready_i = rdy;
    branch_taken_i = tk;
    mdu_done_i = dn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    check();
  endtask

  // applied just after a rising edge that enters FETCH
  task automatic set_insn(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7);
    @(posedge clk);
    #1;
    opcode_i = op;
    funct3_i = f3;
    funct7_i = f7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    step("rst_hold", 1, 0, 0, 0, f_st(3'd0));
    step("rst_hold_rdy", 1, 1, 0, 0, f_st(3'd0));
    step("rst_release", 0, 0, 0, 0, f_st(3'd0));

    // ADDI x1, x0, 5
    set_insn(7'b0010011, 3'b000, 7'b0000000);
    step("addi_fetch", 0, 1, 0, 0, f_fetch(1));
    step("addi_decode", 0, 0, 0, 0, f_st(3'd1));
    step("addi_exec", 0, 0, 0, 0, f_exe(0, 2'b00));
    step("addi_wb", 0, 0, 0, 0, f_wb(2'b01));

    // LW with 3 wait cycles
    set_insn(7'b0000011, 3'b010, 7'b0000000);
    step("lw_fetch_wait", 0, 0, 0, 0, f_fetch(0));
    step("lw_fetch", 0, 1, 0, 0, f_fetch(1));
    step("lw_decode", 0, 0, 0, 0, f_st(3'd1));
    step("lw_exec", 0, 0, 0, 0, f_exe(0, 2'b00));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 0, 0, 0, 0, f_mem(0, 0));
    step("lw_mem_rdy", 0, 1, 0, 0, f_mem(0, 0));
    step("lw_wb", 0, 0, 0, 0, f_wb(2'b10));

    // LW whose data arrives on the last allowed wait cycle
    set_insn(7'b0000011, 3'b010, 7'b0000000);
    step("lwb_fetch", 0, 1, 0, 0, f_fetch(1));
    step("lwb_decode", 0, 0, 0, 0, f_st(3'd1));
    step("lwb_exec", 0, 0, 0, 0, f_exe(0, 2'b00));
    for (int i = 0; i < TO - 1; i++)
      step("lwb_mem_wait", 0, 0, 0, 0, f_mem(0, 0));
    step("lwb_mem_limit_rdy", 0, 1, 0, 0, f_mem(0, 0));
    step("lwb_wb", 0, 0, 0, 0, f_wb(2'b10));

    // SW with memory never ready -> bus timeout trap
    set_insn(7'b0100011, 3'b010, 7'b0000000);
    step("sw_fetch", 0, 1, 0, 0, f_fetch(1));
    step("sw_decode", 0, 0, 0, 0, f_st(3'd1));
    step("sw_exec", 0, 0, 0, 0, f_exe(0, 2'b01));
    for (int i = 0; i < TO; i++)
      step("sw_mem_wait", 0, 0, 0, 0, f_mem(1, 0));
    step("sw_trap", 0, 0, 0, 0, f_trap(2'b01));
    step("sw_after_trap", 0, 0, 0, 0, f_fetch(0));

    // SW completing normally
    set_insn(7'b0100011, 3'b010, 7'b0000000);
    step("sw2_fetch", 0, 1, 0, 0, f_fetch(1));
    step("sw2_decode", 0, 0, 0, 0, f_st(3'd1));
    step("sw2_exec", 0, 0, 0, 0, f_exe(0, 2'b01));
    step("sw2_mem_rdy", 0, 1, 0, 0, f_mem(1, 1));

    // illegal opcode
    set_insn(7'b1111111, 3'b000, 7'b0000000);
    step("ill_fetch", 0, 1, 0, 0, f_fetch(1));
    step("ill_decode", 0, 0, 0, 0, f_st(3'd1));
    step("ill_trap", 0, 0, 0, 0, f_trap(2'b00));

    // BEQ taken
    set_insn(7'b1100011, 3'b000, 7'b0000000);
    step("beq_t_fetch", 0, 1, 0, 0, f_fetch(1));
    step("beq_t_decode", 0, 0, 0, 0, f_st(3'd1));
    e = f_exe(1, 2'b11);
    e.pc_write = 1'b1;
    e.pc_src = 2'b01;
    step("beq_t_exec", 0, 0, 1, 0, e);

    // BEQ not taken
    set_insn(7'b1100011, 3'b000, 7'b0000000);
    step("beq_n_fetch", 0, 1, 0, 0, f_fetch(1));
    step("beq_n_decode", 0, 0, 0, 0, f_st(3'd1));
    e = f_exe(1, 2'b11);
    e.pc_write = 1'b1;
    e.pc_src = 2'b00;
    step("beq_n_exec", 0, 0, 0, 0, e);

    // JAL
    set_insn(7'b1101111, 3'b000, 7'b0000000);
    step("jal_fetch", 0, 1, 0, 0, f_fetch(1));
    step("jal_decode", 0, 0, 0, 0, f_st(3'd1));
    e = f_exe(1, 2'b11);
    e.pc_write = 1'b1;
    e.pc_src = 2'b01;
    e.reg_we = 1'b1;
    e.reg_src = 2'b11;
    step("jal_exec", 0, 0, 0, 0, e);

    // MUL
    set_insn(7'b0110011, 3'b000, 7'b0000001);
    step("mul_fetch", 0, 1, 0, 0, f_fetch(1));
    step("mul_decode", 0, 0, 0, 0, f_st(3'd1));
`ifdef MULTICYCLE_CONTROL_MDU_EN
    e = f_exe(0, 2'b10);
    e.mdu_start = 1'b1;
    step("mul_exec", 0, 0, 0, 0, e);
    for (int i = 0; i < 4; i++)
      step("mul_wait", 0, 0, 0, 0, f_st(3'd5));
    step("mul_wait_done", 0, 0, 0, 1, f_st(3'd5));
    step("mul_wb", 0, 0, 0, 0, f_wb(2'b01));
`else
    step("mul_trap", 0, 0, 0, 0, f_trap(2'b00));
`endif

    // reset in the middle of a load's memory phase
    set_insn(7'b0000011, 3'b010, 7'b0000000);
    step("rstm_fetch", 0, 1, 0, 0, f_fetch(1));
    step("rstm_decode", 0, 0, 0, 0, f_st(3'd1));
    step("rstm_exec", 0, 0, 0, 0, f_exe(0, 2'b00));
    step("rstm_mem", 0, 0, 0, 0, f_mem(0, 0));
    step("rstm_reset", 1, 1, 0, 0, f_st(3'd0));
    step("rstm_release", 0, 0, 0, 0, f_st(3'd0));
    step("rstm_refetch", 0, 0, 0, 0, f_fetch(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles waited for mem_ready_i before bus-error trap; legal 1..255.
REQ-002 Parameter CNT_W, default 8: width of wait counter; SHALL hold MEM_TIMEOUT.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 opcode_i/funct3_i/funct7_i  in  7/3/7  instruction fields from instruction register.
REQ-006 branch_taken_i  in  1  branch comparator result, valid in EXECUTE.
REQ-007 mem_ready_i  in  1  memory completes current request this cycle.
REQ-008 mdu_done_i  in  1  multiply/divide unit result valid (used only with MDU_EN).
REQ-009 mem_req_o, mem_write_enable_o, mem_addr_src_o  out  1 each  request; store; address 0=PC 1=ALU.
REQ-010 ir_write_o, pc_write_o  out  1 each  load IR; update PC.
REQ-011 pc_src_o  out  2  00=PC+4, 01=ALU target, 10=trap vector.
REQ-012 reg_write_enable_o  out  1; reg_write_src_o  out  2  00=imm_u, 01=ALU, 10=mem data, 11=PC+4.
REQ-013 alu_src_1_o  out  1  0=rs1 1=PC; alu_src_2_o  out  2  00=imm_i, 01=imm_s, 10=rs2, 11=imm_u/imm_b/imm_j per opcode.
REQ-014 mdu_start_o  out  1  one-cycle MDU start pulse.
REQ-015 trap_o  out  1  one-cycle trap pulse; trap_cause_o  out  2  00=illegal, 01=bus timeout.
REQ-016 state_o  out  3  current state encoding, debug.

Function
REQ-017 States: FETCH, DECODE, EXECUTE, MEM, WB, MDU_WAIT, TRAP; Moore outputs except ir_write_o/pc_write_o/trap_o, which are qualified by the transition condition.
REQ-018 FETCH: mem_req_o=1, mem_addr_src_o=0 until mem_ready_i; on ready ir_write_o=1 same cycle, -> DECODE.
REQ-019 DECODE: one cycle; legal opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP -> EXECUTE; otherwise -> TRAP cause 00.
REQ-020 EXECUTE: BRANCH writes PC (pc_src_o=01) iff branch_taken_i, else PC+4, -> FETCH; JAL/JALR write rd=PC+4 and PC=ALU -> FETCH; LOAD/STORE -> MEM; others -> WB.
REQ-021 MEM: mem_req_o=1, mem_addr_src_o=1, mem_write_enable_o=1 for STORE; on mem_ready_i STORE -> FETCH with pc_write_o (PC+4), LOAD -> WB.
REQ-022 WB: reg_write_enable_o=1 one cycle with source per opcode; pc_write_o=1, pc_src_o=00; -> FETCH.
REQ-023 Wait counter clears on entry to FETCH/MEM, increments each non-ready cycle; reaching MEM_TIMEOUT with mem_ready_i=0 -> TRAP cause 01; mem_ready_i in the same cycle as the limit wins (no trap).
REQ-024 TRAP: trap_o=1, pc_write_o=1, pc_src_o=10 for one cycle, -> FETCH; no register or memory write.
REQ-025 reg_write_enable_o and mem_write_enable_o SHALL never both be 1.

Reset
REQ-026 rst_i asserted: state=FETCH, counter=0, all outputs 0 except mem_req_o, which is 1 (FETCH) one cycle after release; reset mid-transaction aborts without write or trap.

Configuration
REQ-027 Macro MULTICYCLE_CONTROL_MDU_EN defined: OP with funct7=0000001 decodes as legal; EXECUTE pulses mdu_start_o, -> MDU_WAIT until mdu_done_i, then WB with reg_write_src_o=01.
REQ-028 Macro undefined: funct7=0000001 on OP -> TRAP cause 00; MDU_WAIT unreachable; mdu_start_o tied 0.

Structure
REQ-029 Shared package ctrl_pkg: opcode constants, state enum, pc_src/reg_write_src/alu_src encodings, trap causes.
REQ-030 One sub-module, insn_decode (combinational opcode/funct -> legality and mux selects); FSM and counter in top.

Verification
REQ-031 ADDI, mem_ready_i=1 immediately -> FETCH,DECODE,EXECUTE,WB; reg_write_enable_o=1 in cycle 4, src 01.
REQ-032 LW, data ready after 3 wait cycles -> MEM holds mem_req_o=1 4 cycles, then WB src 10.
REQ-033 SW, mem_ready_i never -> after 15 waits trap_o=1, cause 01, pc_src_o=10, mem_write_enable_o drops.
REQ-034 opcode 7'b1111111 -> TRAP cause 00 cycle after DECODE, no reg write.
REQ-035 BEQ with branch_taken_i=1 -> pc_write_o=1, pc_src_o=01 in EXECUTE; =0 -> pc_src_o=00.
REQ-036 MUL, mdu_done_i after 5 cycles with MDU_EN -> MDU_WAIT 5 cycles then WB; without MDU_EN -> trap cause 00; rst_i mid-MEM -> FETCH, no write.
